regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Write-back arbiter for the single write port of the 2**ADDR_SIZE x WORD_SIZE register file.
- Shares that port between N_REQ write-back sources (ALU, load unit, mul/div) using a valid/ready handshake and round-robin priority.
- Registers the winning write for one cycle before it reaches the regfile write port.
- Exposes the in-flight write so read-side logic can forward it.

Parameters:
- ADDR_SIZE, 5, register address width.
- WORD_SIZE, 32, data width.
- N_REQ, 3, number of requesters (2..8).
- CNT_W, 16, width of per-requester grant counters; used only with the optional feature.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- hold  in  1  pipeline stall; when high, no grants are issued.
- req_valid  in  N_REQ  requester i has a write pending.
- req_ready  out  N_REQ  requester i's write is accepted this cycle (one-hot or zero).
- req_addr  in  N_REQ*ADDR_SIZE  flattened destination addresses; slice i is [i*ADDR_SIZE +: ADDR_SIZE].
- req_data  in  N_REQ*WORD_SIZE  flattened write data, sliced the same way.
- rf_w_en  out  1  registered write enable to the regfile.
- rf_waddr  out  ADDR_SIZE  registered write address.
- rf_wdata  out  WORD_SIZE  registered write data.
- fwd_valid  out  1  equals rf_w_en; the write that commits at the next edge.
- fwd_addr  out  ADDR_SIZE  equals rf_waddr.
- fwd_data  out  WORD_SIZE  equals rf_wdata.
- grant_cnt  out  N_REQ*CNT_W  per-requester grant counts; present only with the optional feature.

Behaviour:
- Clock/reset:
  - One clock, clk. rst is synchronous and active-high.
  - Reset values: rf_w_en=0, rf_waddr=0, rf_wdata=0, rr_ptr=0, all grant counters=0.
- Arbitration (combinational, each cycle):
  - If hold=1 or rst=1, req_ready=0.
  - Otherwise, grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo N_REQ.
  - req_ready is one-hot on the winner, zero if no requester is valid.
  - A transfer occurs when req_valid[i] & req_ready[i].
- Pointer update:
  - On a transfer by requester i, rr_ptr <= (i+1) mod N_REQ.
  - Otherwise rr_ptr holds.
  - Wrap example, N_REQ=3: grant to 2 sets rr_ptr=0.
- Output stage (registered; latency 1 cycle from acceptance to rf_w_en):
  - On a transfer, rf_waddr <= winner's addr and rf_wdata <= winner's data.
  - rf_w_en <= 1 only if the winner's addr != 0.
  - A transfer to addr 0 is still accepted (ready=1) and still advances the pointer, but rf_w_en <= 0. The regfile keeps r0 at zero regardless; suppressing the write avoids bogus forwarding.
  - No transfer: rf_w_en <= 0. rf_waddr and rf_wdata hold their previous values (don't-care while rf_w_en=0).
- Throughput and backpressure:
  - One write per cycle, sustained.
  - The regfile never stalls, so there is no output backpressure and no internal buffering.
- hold:
  - Blocks new grants only.
  - A write already registered still commits (rf_w_en visible in the cycle after hold rises).
- Requester rules:
  - A requester must keep addr and data stable while valid and not ready.
  - The arbiter does not check this.
- Reset mid-operation:
  - In the cycle rst=1, no grant is issued.
  - rf_w_en is 0 the next cycle; any registered write is dropped.
- Simultaneous events:
  - Two requesters targeting the same addr in consecutive cycles commit in grant order; the later write wins.
- Forwarding:
  - fwd_* equal rf_* combinationally.
  - Consumer contract: if fwd_valid and fwd_addr == raddr, use fwd_data instead of the regfile read data.

Optional Feature:
- Macro: REGFILE_WB_ARB_STATS_EN.
- Defined:
  - One saturating CNT_W-bit counter per requester, incremented on each transfer of that requester, including transfers to addr 0.
  - Counters hold at all-ones.
  - Reset to 0 on rst.
  - Exposed on grant_cnt.
- Undefined:
  - The grant_cnt port and the counters are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package regfile_pkg:
  - Default ADDR_SIZE=5, WORD_SIZE=32, REG_ZERO=0, WB_N_REQ=3.
  - Requester index constants: WB_ALU=0, WB_LSU=1, WB_MUL=2.
- One natural sub-module: rr_arbiter.
  - Pure N_REQ-wide round-robin grant logic with its pointer register.
  - Reused by future read-port sharing.

Test Plan:
- Single requester: req_valid=001, addr=5, data=0xDEADBEEF -> ready=001 same cycle; next cycle rf_w_en=1, rf_waddr=5, rf_wdata=0xDEADBEEF, fwd_* match.
- All valid continuously for 6 cycles, from reset -> grants 0,1,2,0,1,2; one rf_w_en per cycle, no gaps.
- Address-0 write: req_valid=010, addr=0, data=0x1234 -> ready=010; next cycle rf_w_en=0; rr_ptr becomes 2.
- hold=1 for 3 cycles with req_valid=111 -> req_ready=000 throughout; a write registered before hold commits once; after hold drops, grants resume at the saved rr_ptr.
- rst asserted while req_valid=100 and a write is registered -> ready=000 that cycle; next cycle rf_w_en=0, rr_ptr=0.
- With REGFILE_WB_ARB_STATS_EN, CNT_W=2: 5 grants to requester 1 -> grant_cnt slice 1 saturates at 3; rst clears it to 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants: geometry defaults and write-back requester indices.
package regfile_pkg;

   localparam int RF_ADDR_SIZE = 5;
   localparam int RF_WORD_SIZE = 32;
   localparam int REG_ZERO     = 0;
   localparam int WB_N_REQ     = 3;

   localparam int WB_ALU = 0;
   localparam int WB_LSU = 1;
   localparam int WB_MUL = 2;

endpackage

// File: rtl/rr_arbiter.sv
// N-wide round-robin arbiter: one-hot grant searching from ptr_q upward with wrap,
// pointer moves to just past the winner on every grant.
module rr_arbiter #(
   parameter int N = 3,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic [N-1:0] valid_i,
   output logic [N-1:0] grant_o
);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] cand_idx;
   logic [PW-1:0] win_idx;
   logic          found;
   int            cand;

   always_comb begin
      grant_o  = '0;
      found    = 1'b0;
      win_idx  = '0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 0; k < N; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= N) cand = cand - N;
         cand_idx = PW'(cand);
         if (en_i && !found && valid_i[cand_idx]) begin
            found             = 1'b1;
            win_idx           = cand_idx;
            grant_o[cand_idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (found) begin
         ptr_q <= (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the single regfile write port, with a one-cycle
// registered write stage mirrored on fwd_*. REGFILE_WB_ARB_STATS_EN adds grant counters.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int ADDR_SIZE = RF_ADDR_SIZE,
   parameter int WORD_SIZE = RF_WORD_SIZE,
   parameter int N_REQ     = WB_N_REQ,
   parameter int CNT_W     = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       hold,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*ADDR_SIZE-1:0] req_addr,
   input  logic [N_REQ*WORD_SIZE-1:0] req_data,
   output logic                       rf_w_en,
   output logic [ADDR_SIZE-1:0]       rf_waddr,
   output logic [WORD_SIZE-1:0]       rf_wdata,
   output logic                       fwd_valid,
   output logic [ADDR_SIZE-1:0]       fwd_addr,
`ifdef REGFILE_WB_ARB_STATS_EN
   output logic [WORD_SIZE-1:0]       fwd_data,
   output logic [N_REQ*CNT_W-1:0]     grant_cnt
`else
   output logic [WORD_SIZE-1:0]       fwd_data
`endif
);

   logic [N_REQ-1:0]     grant;
   logic                 arb_en;
   logic                 xfer;
   logic [ADDR_SIZE-1:0] addr_sel;
   logic [WORD_SIZE-1:0] data_sel;

   logic                 w_en_q;
   logic [ADDR_SIZE-1:0] waddr_q;
   logic [WORD_SIZE-1:0] wdata_q;

   assign arb_en = !hold && !rst;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .en_i    (arb_en),
      .valid_i (req_valid),
      .grant_o (grant)
   );

   assign req_ready = grant;
   assign xfer      = |grant;

   // grant is one-hot, so an OR of masked slices selects the winner's payload
   always_comb begin
      addr_sel = '0;
      data_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            addr_sel = addr_sel | req_addr[i*ADDR_SIZE +: ADDR_SIZE];
            data_sel = data_sel | req_data[i*WORD_SIZE +: WORD_SIZE];
         end
      end
   end

   // Writes to r0 are accepted but never enabled, so forwarding never sees them
   always_ff @(posedge clk) begin
      if (rst) begin
         w_en_q  <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         w_en_q <= xfer && (addr_sel != ADDR_SIZE'(REG_ZERO));
         if (xfer) begin
            waddr_q <= addr_sel;
            wdata_q <= data_sel;
         end
      end
   end

   assign rf_w_en   = w_en_q;
   assign rf_waddr  = waddr_q;
   assign rf_wdata  = wdata_q;
   assign fwd_valid = w_en_q;
   assign fwd_addr  = waddr_q;
   assign fwd_data  = wdata_q;

`ifdef REGFILE_WB_ARB_STATS_EN
   logic [CNT_W-1:0] cnt_q [N_REQ];

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_REQ; i++) begin
         if (rst) begin
            cnt_q[i] <= '0;
         end else if (grant[i] && (cnt_q[i] != '1)) begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < N_REQ; g++) begin : g_cnt_out
      assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then randomized
// traffic, checked against a transaction-level arbitration model.
module tb_regfile_wb_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int N  = 3;
   localparam int CW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            hold;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic            rf_w_en;
   logic [AW-1:0]   rf_waddr;
   logic [DW-1:0]   rf_wdata;
   logic            fwd_valid;
   logic [AW-1:0]   fwd_addr;
   logic [DW-1:0]   fwd_data;
`ifdef REGFILE_WB_ARB_STATS_EN
   logic [N*CW-1:0] grant_cnt;
`endif

   regfile_wb_arbiter #(
      .ADDR_SIZE (AW),
      .WORD_SIZE (DW),
      .N_REQ     (N),
      .CNT_W     (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .hold      (hold),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .rf_w_en   (rf_w_en),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .fwd_valid (fwd_valid),
      .fwd_addr  (fwd_addr),
`ifdef REGFILE_WB_ARB_STATS_EN
      .fwd_data  (fwd_data),
      .grant_cnt (grant_cnt)
`else
      .fwd_data  (fwd_data)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   // scoreboard and model state
   int                 n_cmp = 0;
   int                 n_err = 0;
   logic [AW+DW-1:0]   exp_q[$];
   int                 m_ptr = 0;
   logic               m_wen = 1'b0;
   logic [AW-1:0]      m_waddr = '0;
   logic [DW-1:0]      m_wdata = '0;
   int                 m_cnt[N];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // first valid requester at or after ptr, wrapping; -1 if none
   function automatic int pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   // One clock: check ready mid-cycle, advance the model, check outputs after the edge
   task automatic step(input string tag, output int g);
      logic [N-1:0]     exp_ready;
      logic [AW-1:0]    a;
      logic [DW-1:0]    d;
      logic [AW+DW-1:0] e;
      @(negedge clk);
      g = (rst || hold) ? -1 : pick(req_valid, m_ptr);
      exp_ready = (g >= 0) ? (N'(1) << g) : '0;
      check({tag, ".ready"}, 64'(req_ready), 64'(exp_ready));
      if (rst) begin
         m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_ptr = 0;
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else if (g >= 0) begin
         a = req_addr[g*AW +: AW];
         d = req_data[g*DW +: DW];
         m_waddr = a;
         m_wdata = d;
         m_wen   = (a != '0);
         m_ptr   = (g + 1) % N;
         if (m_cnt[g] < (1 << CW) - 1) m_cnt[g]++;
         if (m_wen) exp_q.push_back({a, d});
      end else begin
         m_wen = 1'b0;
      end
      @(posedge clk);
      #1;
      check({tag, ".w_en"},  64'(rf_w_en),   64'(m_wen));
      check({tag, ".waddr"}, 64'(rf_waddr),  64'(m_waddr));
      check({tag, ".wdata"}, 64'(rf_wdata),  64'(m_wdata));
      check({tag, ".fwd_v"}, 64'(fwd_valid), 64'(m_wen));
      check({tag, ".fwd_a"}, 64'(fwd_addr),  64'(m_waddr));
      check({tag, ".fwd_d"}, 64'(fwd_data),  64'(m_wdata));
      if (rf_w_en) begin
         if (exp_q.size() == 0) begin
            check({tag, ".unexpected_commit"}, 64'(1), 64'(0));
         end else begin
            e = exp_q.pop_front();
            check({tag, ".commit"}, 64'({rf_waddr, rf_wdata}), 64'(e));
         end
      end
`ifdef REGFILE_WB_ARB_STATS_EN
      for (int i = 0; i < N; i++) begin
         check({tag, ".cnt"}, 64'(grant_cnt[i*CW +: CW]), 64'(m_cnt[i]));
      end
`endif
   endtask

   initial begin
      int g;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      rst = 1'b1; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
      step("reset", g);
      rst = 1'b0;

      // single requester, visible on rf_* and fwd_* one cycle later
      req_valid = 3'b001;
      set_req(0, 5'd5, 32'hDEADBEEF);
      step("single", g);
      check("single.grant", 64'(g), 64'(0));
      req_valid = '0;
      step("single_idle", g);

      // all valid from reset: 0,1,2,0,1,2 back to back
      rst = 1'b1; step("rr_reset", g); rst = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), 32'hA000_0000 + i);
      req_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         step("rr", g);
         check("rr.order", 64'(g), 64'(k % 3));
      end

      // address-0 write is accepted but not enabled; pointer moves to 2
      req_valid = 3'b010;
      set_req(1, 5'd0, 32'h1234);
      step("zero", g);
      req_valid = 3'b111;
      set_req(1, 5'd7, 32'h77);
      step("zero_next", g);
      check("zero.ptr", 64'(g), 64'(2));

      // hold: registered write commits, no grants, resume at saved pointer
      step("pre_hold", g);
      hold = 1'b1;
      for (int k = 0; k < 3; k++) step("hold", g);
      hold = 1'b0;
      step("post_hold", g);
      check("post_hold.grant", 64'(g), 64'(1));

      // reset mid-operation drops the registered write
      step("pre_rst", g);
      req_valid = 3'b100;
      rst = 1'b1;
      step("mid_rst", g);
      rst = 1'b0;
      req_valid = 3'b111;
      step("after_rst", g);
      check("after_rst.ptr", 64'(g), 64'(0));

      // five grants to requester 1 saturate a 2-bit counter; reset clears it
      req_valid = 3'b010;
      set_req(1, 5'd9, 32'h99);
      for (int k = 0; k < 5; k++) step("sat", g);
      rst = 1'b1; step("sat_rst", g); rst = 1'b0;

      // randomized traffic: valid stays up until granted, payload fixed meanwhile
      req_valid = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
               req_valid[i] = 1'b1;
               set_req(i, ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(0, 31)), $urandom());
            end
         end
         hold = ($urandom_range(0, 9) == 0);
         rst  = ($urandom_range(0, 49) == 0);
         step("rand", g);
         if (g >= 0) req_valid[g] = 1'b0;
      end
      rst = 1'b0; hold = 1'b0; req_valid = '0;
      step("drain", g);
      check("queue_empty", 64'(exp_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
